sdf_stage_ctrl: RTL
===================

# sdf_stage_ctrl

Sequencing controller for one radix-2 single-delay-feedback (SDF) FFT stage built around the 16-lane shift-register delay buffer. It counts input beats, fills the buffer, and switches the stage between pass/fill and butterfly phases. It generates the buffer shift enable, the butterfly select, the twiddle index and the output framing, and drains the buffer at end of stream. One instance sits beside each stage's delay buffer and butterfly.

## Interface
- DEPTH, 256, delay buffer depth in samples; must be a multiple of LANES.
- LANES, 16, samples per beat.
- Derived localparam HALF = DEPTH/LANES beats (16 at defaults); frame = 2*HALF beats.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat of LANES samples present this cycle.
- in_sof  in  1  qualifies the in_valid beat as beat 0 of a frame.
- flush  in  1  level request: drain the buffer after the current frame.
- buf_shift_en  out  1  delay buffer shifts on this edge.
- bf_sel  out  1  1 = butterfly phase (sum out, difference into buffer); 0 = input into buffer, buffer output out.
- tw_idx  out  $clog2(HALF)  twiddle index for the butterfly beat.
- out_valid  out  1  stage output beat valid this cycle.
- out_sof  out  1  first output beat of a frame.
- busy  out  1  state != IDLE.
- err_sof  out  1  one-cycle pulse on a misaligned in_sof (see Configuration).

## Operation
- State register: IDLE, FILL, BFLY, DRAIN.
- Beat counter cnt ranges 0..HALF-1.
- primed flag: set once the buffer holds the differences of a prior frame.
- IDLE:
  - in_valid&&in_sof: accept the beat as beat 0, go to FILL with cnt=1, primed=0.
  - in_valid without in_sof: beat dropped, no shift, err_sof pulses.
- FILL:
  - Each in_valid beat: shift, bf_sel=0, cnt++.
  - out_valid = in_valid && primed.
  - Valid beat at cnt==HALF-1: go to BFLY, cnt=0.
- BFLY:
  - Each in_valid beat: shift, bf_sel=1, out_valid=1, tw_idx=cnt, cnt++.
  - out_sof = 1 on the cnt==0 beat.
  - Valid beat at cnt==HALF-1: go to FILL, cnt=0, primed=1.
- Flush (only evaluated in FILL with cnt==0 and primed):
  - flush && !in_valid: go to DRAIN.
  - in_valid present: the input beat has priority and flush stays pending.
- DRAIN:
  - Every cycle: shift, bf_sel=0, out_valid=1; in_valid is ignored and in_sof is not flagged.
  - After HALF cycles: go to IDLE, cnt=0, primed=0.
- Input gaps: in FILL/BFLY with in_valid=0, no shift, no counter change, all strobes 0.
- Outputs in IDLE: buf_shift_en, bf_sel, out_valid, out_sof, busy all 0; tw_idx 0.

## Timing
- buf_shift_en, bf_sel, tw_idx, out_valid and out_sof are combinational from registered state/cnt and in_valid, and align with the input beat on the same edge.
- The stage adds no extra register latency beyond the buffer itself.
- Differences of frame k emerge HALF valid beats later, during FILL of frame k+1 or during DRAIN.
- Reset values: state=IDLE, cnt=0, primed=0, err_sof=0; combinational outputs resolve to 0.
- Reset mid-operation aborts immediately to IDLE. The buffer shares rstn, so no stale data survives.
- Back-to-back frames: FILL at cnt==0 accepts the next frame's beat 0 with or without in_sof.

## Configuration
- SDF_CTRL_ERR_EN defined:
  - in_sof on a valid beat in FILL/BFLY with cnt!=0 pulses err_sof for one cycle. The beat is still processed normally; there is no resync.
  - in_sof absent on beat 0 of a frame started from FILL cnt==0 also pulses err_sof.
  - In IDLE, in_valid without in_sof pulses err_sof.
- Undefined:
  - err_sof is tied 0.
  - in_sof is used only to leave IDLE.
  - In IDLE, in_valid without in_sof is still dropped silently (no shift).

## Structure
- Shared package fft_ctrl_pkg holds the state enum sdf_state_e and the function for HALF/counter width.
- No sub-module; the state register, cnt and primed fit inline.

## Test plan
All scenarios use the default parameters (DEPTH=256, LANES=16).
- Reset release, 32 continuous valid beats with in_sof on beat 0 -> FILL for 16 beats with out_valid=0, BFLY for 16 beats with out_valid=1, out_sof on beat 16, tw_idx 0..15.
- Two back-to-back frames, then flush=1 with in_valid=0 -> frame-2 FILL out_valid=1 for all 16 beats; DRAIN 16 cycles with out_valid=1; then IDLE, busy=0.
- Frame with in_valid deasserted every other cycle -> no shift and no cnt advance on gaps; tw_idx sequence unchanged 0..15.
- flush=1 held while frame-3 beat 0 arrives at FILL cnt==0 -> beat accepted, DRAIN only after frame 3 BFLY completes.
- With SDF_CTRL_ERR_EN, in_sof on FILL beat 5 -> err_sof single pulse, counting continues to BFLY at beat 16; without the macro, err_sof stays 0.
- rstn asserted during BFLY beat 7 -> all outputs 0 asynchronously; the next frame restarts cleanly from IDLE with out_valid=0 for 16 beats.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared types and sizing helpers for the FFT stage controllers.
// Holds the SDF stage state enum and the beat/counter width helpers.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_BFLY  = 2'd2,
    S_DRAIN = 2'd3
  } sdf_state_e;

  function automatic int half_beats(
    input int depth,
    input int lanes
  );
    return depth / lanes;
  endfunction

  function automatic int cnt_w(input int half);
    return (half > 1) ? $clog2(half) : 1;
  endfunction

endpackage

// File: rtl/sdf_stage_ctrl_if.sv
// Handshake/control bundle between an SDF stage controller and its datapath.
// master: drives in_valid/in_sof/flush; slave: drives the strobes and status.
interface sdf_stage_ctrl_if #(
  parameter int TW_W = 4
);
  logic            in_valid;
  logic            in_sof;
  logic            flush;
  logic            buf_shift_en;
  logic            bf_sel;
  logic [TW_W-1:0] tw_idx;
  logic            out_valid;
  logic            out_sof;
  logic            busy;
  logic            err_sof;

  modport master (
    output in_valid, in_sof, flush,
    input  buf_shift_en, bf_sel, tw_idx,
    input  out_valid, out_sof, busy, err_sof
  );

  modport slave (
    input  in_valid, in_sof, flush,
    output buf_shift_en, bf_sel, tw_idx,
    output out_valid, out_sof, busy, err_sof
  );
endinterface

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: fill/butterfly/drain phasing.
// Ports: clk, rstn (async low), bus (slave). Macro SDF_CTRL_ERR_EN enables err_sof.
module sdf_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LANES = 16
) (
  input  logic            clk,
  input  logic            rstn,
  sdf_stage_ctrl_if.slave bus
);

  localparam int HALF = half_beats(DEPTH, LANES);
  localparam int CW   = cnt_w(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  sdf_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_primed;

  logic w_idle;
  logic w_fill;
  logic w_bfly;
  logic w_drain;
  logic w_start;
  logic w_last;

  assign w_idle  = (r_state == S_IDLE);
  assign w_fill  = (r_state == S_FILL);
  assign w_bfly  = (r_state == S_BFLY);
  assign w_drain = (r_state == S_DRAIN);
  assign w_start = w_idle & bus.in_valid & bus.in_sof;
  assign w_last  = (r_cnt == LAST);

  // the accepted beat 0 from IDLE enters the buffer like any fill beat
  assign bus.buf_shift_en = w_start | w_drain
                          | ((w_fill | w_bfly) & bus.in_valid);
  assign bus.bf_sel       = w_bfly & bus.in_valid;
  assign bus.tw_idx       = (w_bfly & bus.in_valid) ? r_cnt : '0;
  assign bus.out_valid    = w_drain
                          | (w_bfly & bus.in_valid)
                          | (w_fill & bus.in_valid & r_primed);
  assign bus.out_sof      = w_bfly & bus.in_valid & (r_cnt == '0);
  assign bus.busy         = ~w_idle;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_primed <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_FILL;
            r_cnt    <= CW'(1);
            r_primed <= 1'b0;
          end
        end
        S_FILL: begin
          if (bus.in_valid) begin
            if (w_last) begin
              r_state <= S_BFLY;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (bus.flush && r_primed
                       && (r_cnt == '0)) begin
            r_state <= S_DRAIN;
          end
        end
        S_BFLY: begin
          if (bus.in_valid) begin
            if (w_last) begin
              r_state  <= S_FILL;
              r_cnt    <= '0;
              r_primed <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_last) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_primed <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SDF_CTRL_ERR_EN
  logic r_err;
  logic w_err;

  // sof on a mid-frame beat, missing sof on a chained beat 0, or a stray idle beat
  assign w_err = (w_idle & bus.in_valid & ~bus.in_sof)
               | ((w_fill | w_bfly) & bus.in_valid
                  & bus.in_sof & (r_cnt != '0))
               | (w_fill & bus.in_valid & ~bus.in_sof
                  & r_primed & (r_cnt == '0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_err <= 1'b0;
    else       r_err <= w_err;
  end

  assign bus.err_sof = r_err;
`else
  assign bus.err_sof = 1'b0;
`endif

endmodule
